// File: rtl/fetch_sched.sv
// Fetch sequencer: arbitrates redirects, issues credit-limited 8-byte I-cache requests,
// drops stale responses after a redirect and buffers instruction pairs for the IQ.
// Optional build macro FETCH_SCHED_PERF_EN adds redirect and starvation counters.
module fetch_sched #(
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BOOT_ADDR  = '0,
  parameter int unsigned           MAX_OUT    = 2,
  parameter int unsigned           BUF_DEPTH  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  exc_redirect_i,
  input  logic [ADDR_WIDTH-1:0] exc_addr_i,
  input  logic                  bru_miss_i,
  input  logic [ADDR_WIDTH-1:0] bru_addr_i,
  input  logic                  bpu_taken_i,
  input  logic [ADDR_WIDTH-1:0] bpu_addr_i,
  input  logic                  interrupt_stall_i,
  output logic                  icache_req_valid_o,
  output logic [ADDR_WIDTH-1:0] icache_req_addr_o,
  input  logic                  icache_req_ready_i,
  input  logic                  icache_resp_valid_i,
  input  logic [63:0]           icache_resp_data_i,
  output logic                  inst_valid_o,
  output logic [31:0]           inst0_o,
  output logic [31:0]           inst1_o,
  output logic [ADDR_WIDTH-1:0] inst_pc_o,
  input  logic                  instr_queue_ready_i,
  output logic                  misaligned_exception_o,
  output logic [ADDR_WIDTH-1:0] misaligned_addr_o
`ifdef FETCH_SCHED_PERF_EN
  ,
  output logic [31:0]           perf_redirect_cnt_o,
  output logic [31:0]           perf_starve_cnt_o
`endif
);

  localparam int unsigned CntW = $clog2(BUF_DEPTH + 1);
  localparam int unsigned AfW  = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
  localparam int unsigned BfW  = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;

  typedef enum logic [1:0] {StRun, StHold, StFault} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [CntW-1:0]       out_cnt_q, out_cnt_d;
  logic [CntW-1:0]       drop_cnt_q, drop_cnt_d;
  logic [ADDR_WIDTH-1:0] mis_addr_q, mis_addr_d;

  // Issue-address FIFO: one entry per outstanding request, popped by every response.
  logic [ADDR_WIDTH-1:0] af_mem_q [MAX_OUT];
  logic [ADDR_WIDTH-1:0] af_mem_d [MAX_OUT];
  logic [AfW-1:0]        af_wr_q, af_wr_d, af_rd_q, af_rd_d;

  // Response buffer feeding the instruction queue.
  logic [63:0]           buf_data_q [BUF_DEPTH];
  logic [63:0]           buf_data_d [BUF_DEPTH];
  logic [ADDR_WIDTH-1:0] buf_pc_q [BUF_DEPTH];
  logic [ADDR_WIDTH-1:0] buf_pc_d [BUF_DEPTH];
  logic [BfW-1:0]        buf_wr_q, buf_wr_d, buf_rd_q, buf_rd_d;
  logic [CntW-1:0]       buf_cnt_q, buf_cnt_d;

  logic                  redir_acc, redir_misal;
  logic [ADDR_WIDTH-1:0] redir_tgt;
  logic                  has_space, req_hs, resp_ok, push, pop;

  logic unused_bpu_low;
  assign unused_bpu_low = ^bpu_addr_i[1:0];

  // Redirect arbitration; bru is ignored while faulted.
  always_comb begin
    redir_acc = 1'b0;
    redir_tgt = exc_addr_i;
    if (exc_redirect_i) begin
      redir_acc = 1'b1;
      redir_tgt = exc_addr_i;
    end else if (bru_miss_i && (state_q != StFault)) begin
      redir_acc = 1'b1;
      redir_tgt = bru_addr_i;
    end
    redir_misal = redir_acc && (redir_tgt[1:0] != 2'b00);
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= StRun;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StRun:   if (interrupt_stall_i) state_d = StHold;
      StHold:  if (!interrupt_stall_i) state_d = StRun;
      StFault: state_d = StFault;
      default: state_d = StRun;
    endcase
    if (redir_acc) begin
      if (redir_misal)              state_d = StFault;
      else if (state_q == StFault)  state_d = StRun;
    end
  end

  // FSM outputs: issue gating and fault flag.
  always_comb begin
    // Count in-flight plus buffered so every in-flight response is guaranteed a slot.
    has_space = (({1'b0, out_cnt_q} + {1'b0, buf_cnt_q}) < (CntW + 1)'(BUF_DEPTH));
    icache_req_valid_o = !rst && (state_q == StRun) && !(exc_redirect_i || bru_miss_i) &&
                         has_space && (out_cnt_q < CntW'(MAX_OUT));
    misaligned_exception_o = (state_q == StFault);
  end

  assign req_hs  = icache_req_valid_o && icache_req_ready_i;
  assign resp_ok = icache_resp_valid_i && (out_cnt_q != '0);
  assign push    = resp_ok && (drop_cnt_q == '0) && !redir_acc;
  assign pop     = (buf_cnt_q != '0) && instr_queue_ready_i && !redir_acc;

  // Datapath next-state: PC, credit counters, issue FIFO and response buffer.
  always_comb begin
    pc_d       = pc_q;
    out_cnt_d  = out_cnt_q + CntW'(req_hs) - CntW'(resp_ok);
    drop_cnt_d = drop_cnt_q;
    mis_addr_d = mis_addr_q;
    af_mem_d   = af_mem_q;
    af_wr_d    = af_wr_q;
    af_rd_d    = af_rd_q;
    buf_data_d = buf_data_q;
    buf_pc_d   = buf_pc_q;
    buf_wr_d   = buf_wr_q;
    buf_rd_d   = buf_rd_q;
    buf_cnt_d  = buf_cnt_q;

    if (redir_acc && !redir_misal) begin
      pc_d = redir_tgt;
    end else if (req_hs) begin
      pc_d = bpu_taken_i ? {bpu_addr_i[ADDR_WIDTH-1:2], 2'b00} : pc_q + ADDR_WIDTH'(8);
    end

    if (redir_misal)                               mis_addr_d = redir_tgt;
    else if (redir_acc && (state_q == StFault))    mis_addr_d = '0;

    // Everything still in flight after this cycle belongs to the old stream.
    if (redir_acc)                           drop_cnt_d = out_cnt_q - CntW'(resp_ok);
    else if (resp_ok && (drop_cnt_q != '0))  drop_cnt_d = drop_cnt_q - CntW'(1);

    if (req_hs) begin
      af_mem_d[af_wr_q] = pc_q;
      af_wr_d = (af_wr_q == AfW'(MAX_OUT - 1)) ? '0 : af_wr_q + AfW'(1);
    end
    if (resp_ok) begin
      af_rd_d = (af_rd_q == AfW'(MAX_OUT - 1)) ? '0 : af_rd_q + AfW'(1);
    end

    if (redir_acc) begin
      buf_wr_d  = '0;
      buf_rd_d  = '0;
      buf_cnt_d = '0;
    end else begin
      if (push) begin
        buf_data_d[buf_wr_q] = icache_resp_data_i;
        buf_pc_d[buf_wr_q]   = af_mem_q[af_rd_q];
        buf_wr_d = (buf_wr_q == BfW'(BUF_DEPTH - 1)) ? '0 : buf_wr_q + BfW'(1);
      end
      if (pop) begin
        buf_rd_d = (buf_rd_q == BfW'(BUF_DEPTH - 1)) ? '0 : buf_rd_q + BfW'(1);
      end
      buf_cnt_d = buf_cnt_q + CntW'(push) - CntW'(pop);
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q       <= BOOT_ADDR;
      out_cnt_q  <= '0;
      drop_cnt_q <= '0;
      mis_addr_q <= '0;
      af_wr_q    <= '0;
      af_rd_q    <= '0;
      buf_wr_q   <= '0;
      buf_rd_q   <= '0;
      buf_cnt_q  <= '0;
      for (int i = 0; i < MAX_OUT; i++) af_mem_q[i] <= '0;
      for (int i = 0; i < BUF_DEPTH; i++) begin
        buf_data_q[i] <= '0;
        buf_pc_q[i]   <= '0;
      end
    end else begin
      pc_q       <= pc_d;
      out_cnt_q  <= out_cnt_d;
      drop_cnt_q <= drop_cnt_d;
      mis_addr_q <= mis_addr_d;
      af_wr_q    <= af_wr_d;
      af_rd_q    <= af_rd_d;
      buf_wr_q   <= buf_wr_d;
      buf_rd_q   <= buf_rd_d;
      buf_cnt_q  <= buf_cnt_d;
      af_mem_q   <= af_mem_d;
      buf_data_q <= buf_data_d;
      buf_pc_q   <= buf_pc_d;
    end
  end

  assign icache_req_addr_o = pc_q;
  assign inst_valid_o      = (buf_cnt_q != '0);
  assign inst0_o           = buf_data_q[buf_rd_q][31:0];
  assign inst1_o           = buf_data_q[buf_rd_q][63:32];
  assign inst_pc_o         = buf_pc_q[buf_rd_q];
  assign misaligned_addr_o = mis_addr_q;

  // A response with nothing outstanding is a protocol violation by the I-cache.
  resp_without_req_a: assert property (@(posedge clk) disable iff (rst)
    !(icache_resp_valid_i && (out_cnt_q == '0)));

`ifdef FETCH_SCHED_PERF_EN
  logic [31:0] perf_redir_q, perf_redir_d, perf_starve_q, perf_starve_d;

  // Saturating counters, frozen while faulted.
  always_comb begin
    perf_redir_d  = perf_redir_q;
    perf_starve_d = perf_starve_q;
    if (state_q != StFault) begin
      if (redir_acc && (perf_redir_q != '1)) perf_redir_d = perf_redir_q + 32'd1;
      if (instr_queue_ready_i && !inst_valid_o && (perf_starve_q != '1)) begin
        perf_starve_d = perf_starve_q + 32'd1;
      end
    end
  end

  // Counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_redir_q  <= '0;
      perf_starve_q <= '0;
    end else begin
      perf_redir_q  <= perf_redir_d;
      perf_starve_q <= perf_starve_d;
    end
  end

  assign perf_redirect_cnt_o = perf_redir_q;
  assign perf_starve_cnt_o   = perf_starve_q;
`else
  // Performance counters compiled out.
`endif

endmodule

// File: tb/tb_fetch_sched.sv
// Directed bench for fetch_sched: per-cycle vector table plus hand sequences for
// buffer back-pressure and interrupt stall.
module tb_fetch_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        exc_redirect_i, bru_miss_i, bpu_taken_i, interrupt_stall_i;
  logic [31:0] exc_addr_i, bru_addr_i, bpu_addr_i;
  logic        icache_req_valid_o, icache_req_ready_i, icache_resp_valid_i;
  logic [31:0] icache_req_addr_o;
  logic [63:0] icache_resp_data_i;
  logic        inst_valid_o, instr_queue_ready_i, misaligned_exception_o;
  logic [31:0] inst0_o, inst1_o, inst_pc_o, misaligned_addr_o;

  fetch_sched dut (
    .clk                    (clk),
    .rst                    (rst),
    .exc_redirect_i         (exc_redirect_i),
    .exc_addr_i             (exc_addr_i),
    .bru_miss_i             (bru_miss_i),
    .bru_addr_i             (bru_addr_i),
    .bpu_taken_i            (bpu_taken_i),
    .bpu_addr_i             (bpu_addr_i),
    .interrupt_stall_i      (interrupt_stall_i),
    .icache_req_valid_o     (icache_req_valid_o),
    .icache_req_addr_o      (icache_req_addr_o),
    .icache_req_ready_i     (icache_req_ready_i),
    .icache_resp_valid_i    (icache_resp_valid_i),
    .icache_resp_data_i     (icache_resp_data_i),
    .inst_valid_o           (inst_valid_o),
    .inst0_o                (inst0_o),
    .inst1_o                (inst1_o),
    .inst_pc_o              (inst_pc_o),
    .instr_queue_ready_i    (instr_queue_ready_i),
    .misaligned_exception_o (misaligned_exception_o),
    .misaligned_addr_o      (misaligned_addr_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        exc;
    logic [31:0] exc_addr;
    logic        bru;
    logic [31:0] bru_addr;
    logic        bpu;
    logic [31:0] bpu_addr;
    logic        stall;
    logic        rdy;
    logic        rv;
    logic [63:0] rdata;
    logic        iqr;
    logic        e_vld;
    logic [31:0] e_addr;
    logic        e_iv;
    logic [31:0] e_pc;
    logic [63:0] e_data;
    logic        e_mis;
    logic [31:0] e_maddr;
  } vec_t;

  localparam logic        N  = 1'b0;
  localparam logic        Y  = 1'b1;
  localparam logic [31:0] Z  = 32'h0;
  localparam logic [63:0] ZD = 64'h0;
  localparam logic [63:0] D0 = 64'h1111_0004_1111_0000;
  localparam logic [63:0] D1 = 64'h2222_000c_2222_0008;
  localparam logic [63:0] D2 = 64'h3333_0104_3333_0100;
  localparam logic [63:0] D3 = 64'h4444_010c_4444_0108;
  localparam logic [63:0] D4 = 64'hdead_0114_dead_0110;
  localparam logic [63:0] D5 = 64'hdead_011c_dead_0118;
  localparam logic [63:0] D6 = 64'h5555_0204_5555_0200;
  localparam logic [63:0] D7 = 64'h6666_0044_6666_0040;
  localparam logic [63:0] DB0 = 64'h7777_004c_7777_0048;
  localparam logic [63:0] DB1 = 64'h8888_0054_8888_0050;
  localparam logic [63:0] DS  = 64'h9999_005c_9999_0058;

  localparam int NumVec = 23;
  vec_t vecs [NumVec];

  int   checks = 0;
  int   errors = 0;
  int   hs_n;
  int   nresp;
  logic hs_prev;

  task automatic check(input string name, input int idx, input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: got %0h, expected %0h", name, idx, got, exp);
    end
  endtask

  task automatic idle();
    exc_redirect_i      = 1'b0;
    exc_addr_i          = '0;
    bru_miss_i          = 1'b0;
    bru_addr_i          = '0;
    bpu_taken_i         = 1'b0;
    bpu_addr_i          = '0;
    interrupt_stall_i   = 1'b0;
    icache_req_ready_i  = 1'b0;
    icache_resp_valid_i = 1'b0;
    icache_resp_data_i  = '0;
    instr_queue_ready_i = 1'b0;
  endtask

  initial begin
    //          exc addr     bru addr       bpu addr       st rdy rv data iqr
    //          | vld addr       iv pc        data mis maddr
    vecs[0]  = '{N,Z,N,Z,N,Z,N,Y,N,ZD,Y, Y,32'h0,N,Z,ZD,N,Z};
    vecs[1]  = '{N,Z,N,Z,Y,32'h103,N,Y,Y,D0,Y, Y,32'h8,N,Z,ZD,N,Z};
    vecs[2]  = '{N,Z,N,Z,N,Z,N,Y,Y,D1,Y, N,32'h100,Y,32'h0,D0,N,Z};
    vecs[3]  = '{N,Z,N,Z,N,Z,N,Y,N,ZD,Y, Y,32'h100,Y,32'h8,D1,N,Z};
    vecs[4]  = '{N,Z,N,Z,N,Z,N,Y,Y,D2,Y, Y,32'h108,N,Z,ZD,N,Z};
    vecs[5]  = '{N,Z,N,Z,N,Z,N,N,Y,D3,Y, N,32'h110,Y,32'h100,D2,N,Z};
    vecs[6]  = '{N,Z,N,Z,N,Z,N,Y,N,ZD,Y, Y,32'h110,Y,32'h108,D3,N,Z};
    vecs[7]  = '{N,Z,N,Z,N,Z,N,Y,N,ZD,Y, Y,32'h118,N,Z,ZD,N,Z};
    vecs[8]  = '{N,Z,Y,32'h200,N,Z,N,Y,N,ZD,Y, N,32'h120,N,Z,ZD,N,Z};
    vecs[9]  = '{N,Z,N,Z,N,Z,N,Y,Y,D4,Y, N,32'h200,N,Z,ZD,N,Z};
    vecs[10] = '{N,Z,N,Z,N,Z,N,Y,Y,D5,Y, Y,32'h200,N,Z,ZD,N,Z};
    vecs[11] = '{N,Z,N,Z,N,Z,N,N,Y,D6,Y, Y,32'h208,N,Z,ZD,N,Z};
    vecs[12] = '{N,Z,N,Z,N,Z,N,N,N,ZD,Y, Y,32'h208,Y,32'h200,D6,N,Z};
    vecs[13] = '{Y,32'h80,Y,32'h200,N,Z,N,N,N,ZD,N, N,32'h208,N,Z,ZD,N,Z};
    vecs[14] = '{N,Z,N,Z,N,Z,N,N,N,ZD,N, Y,32'h80,N,Z,ZD,N,Z};
    vecs[15] = '{N,Z,Y,32'h202,N,Z,N,N,N,ZD,N, N,32'h80,N,Z,ZD,N,Z};
    vecs[16] = '{N,Z,N,Z,N,Z,N,Y,N,ZD,N, N,32'h80,N,Z,ZD,Y,32'h202};
    vecs[17] = '{N,Z,Y,32'h300,N,Z,N,Y,N,ZD,N, N,32'h80,N,Z,ZD,Y,32'h202};
    vecs[18] = '{N,Z,N,Z,N,Z,N,Y,N,ZD,N, N,32'h80,N,Z,ZD,Y,32'h202};
    vecs[19] = '{Y,32'h40,N,Z,N,Z,N,Y,N,ZD,N, N,32'h80,N,Z,ZD,Y,32'h202};
    vecs[20] = '{N,Z,N,Z,N,Z,N,Y,N,ZD,N, Y,32'h40,N,Z,ZD,N,Z};
    vecs[21] = '{N,Z,N,Z,N,Z,N,N,Y,D7,N, Y,32'h48,N,Z,ZD,N,Z};
    vecs[22] = '{N,Z,N,Z,N,Z,N,N,N,ZD,Y, Y,32'h48,Y,32'h40,D7,N,Z};

    // Reset: outputs quiet even with the I-cache ready.
    idle();
    rst = 1'b1;
    icache_req_ready_i  = 1'b1;
    instr_queue_ready_i = 1'b1;
    #2;
    check("rst_req_valid", 0, 64'(icache_req_valid_o), 64'h0);
    check("rst_req_addr", 0, 64'(icache_req_addr_o), 64'h0);
    check("rst_inst_valid", 0, 64'(inst_valid_o), 64'h0);
    check("rst_inst", 0, {inst1_o, inst0_o}, 64'h0);
    check("rst_inst_pc", 0, 64'(inst_pc_o), 64'h0);
    check("rst_mis", 0, 64'(misaligned_exception_o), 64'h0);
    check("rst_mis_addr", 0, 64'(misaligned_addr_o), 64'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Per-cycle table: drive after negedge, compare before the next posedge.
    for (int i = 0; i < NumVec; i++) begin
      if (i != 0) @(negedge clk);
      exc_redirect_i      = vecs[i].exc;
      exc_addr_i          = vecs[i].exc_addr;
      bru_miss_i          = vecs[i].bru;
      bru_addr_i          = vecs[i].bru_addr;
      bpu_taken_i         = vecs[i].bpu;
      bpu_addr_i          = vecs[i].bpu_addr;
      interrupt_stall_i   = vecs[i].stall;
      icache_req_ready_i  = vecs[i].rdy;
      icache_resp_valid_i = vecs[i].rv;
      icache_resp_data_i  = vecs[i].rdata;
      instr_queue_ready_i = vecs[i].iqr;
      #1;
      check("req_valid", i, 64'(icache_req_valid_o), 64'(vecs[i].e_vld));
      check("req_addr", i, 64'(icache_req_addr_o), 64'(vecs[i].e_addr));
      check("inst_valid", i, 64'(inst_valid_o), 64'(vecs[i].e_iv));
      if (vecs[i].e_iv) begin
        check("inst_pc", i, 64'(inst_pc_o), 64'(vecs[i].e_pc));
        check("inst_data", i, {inst1_o, inst0_o}, vecs[i].e_data);
      end
      check("mis_exc", i, 64'(misaligned_exception_o), 64'(vecs[i].e_mis));
      check("mis_addr", i, 64'(misaligned_addr_o), 64'(vecs[i].e_maddr));
    end

    // Consumer stalled for 10 cycles with a 1-cycle-latency I-cache: two pairs fill the
    // buffer and issue stops.
    hs_n    = 0;
    nresp   = 0;
    hs_prev = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      idle();
      icache_req_ready_i  = 1'b1;
      icache_resp_valid_i = hs_prev;
      icache_resp_data_i  = (nresp == 0) ? DB0 : DB1;
      if (hs_prev) nresp++;
      #1;
      hs_prev = icache_req_valid_o && icache_req_ready_i;
      if (hs_prev) hs_n++;
    end
    @(negedge clk);
    idle();
    icache_req_ready_i  = 1'b1;
    instr_queue_ready_i = 1'b1;
    #1;
    check("bp_handshakes", 0, 64'(hs_n), 64'd2);
    check("bp_req_valid", 0, 64'(icache_req_valid_o), 64'h0);
    check("bp_req_addr", 0, 64'(icache_req_addr_o), 64'h58);
    check("bp_inst_valid", 0, 64'(inst_valid_o), 64'h1);
    check("bp_inst_pc", 0, 64'(inst_pc_o), 64'h48);
    check("bp_inst_data", 0, {inst1_o, inst0_o}, DB0);

    // Stall raised in the issuing cycle: that request goes out, nothing after it, and
    // its response is still buffered and delivered.
    @(negedge clk);
    idle();
    icache_req_ready_i = 1'b1;
    interrupt_stall_i  = 1'b1;
    #1;
    check("st_req_valid", 0, 64'(icache_req_valid_o), 64'h1);
    check("st_req_addr", 0, 64'(icache_req_addr_o), 64'h58);
    check("st_inst_pc", 0, 64'(inst_pc_o), 64'h50);

    @(negedge clk);
    idle();
    icache_req_ready_i  = 1'b1;
    interrupt_stall_i   = 1'b1;
    icache_resp_valid_i = 1'b1;
    icache_resp_data_i  = DS;
    instr_queue_ready_i = 1'b1;
    #1;
    check("st_req_valid", 1, 64'(icache_req_valid_o), 64'h0);
    check("st_inst_valid", 1, 64'(inst_valid_o), 64'h1);
    check("st_inst_pc", 1, 64'(inst_pc_o), 64'h50);
    check("st_inst_data", 1, {inst1_o, inst0_o}, DB1);

    @(negedge clk);
    idle();
    icache_req_ready_i  = 1'b1;
    interrupt_stall_i   = 1'b1;
    instr_queue_ready_i = 1'b1;
    #1;
    check("st_req_valid", 2, 64'(icache_req_valid_o), 64'h0);
    check("st_inst_valid", 2, 64'(inst_valid_o), 64'h1);
    check("st_inst_pc", 2, 64'(inst_pc_o), 64'h58);
    check("st_inst_data", 2, {inst1_o, inst0_o}, DS);

    // Stall drops: one more quiet cycle in HOLD, then issue resumes.
    @(negedge clk);
    idle();
    icache_req_ready_i = 1'b1;
    #1;
    check("st_req_valid", 3, 64'(icache_req_valid_o), 64'h0);
    check("st_inst_valid", 3, 64'(inst_valid_o), 64'h0);

    @(negedge clk);
    idle();
    #1;
    check("st_req_valid", 4, 64'(icache_req_valid_o), 64'h1);
    check("st_req_addr", 4, 64'(icache_req_addr_o), 64'h60);

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_sched.md
Name: fetch_sched

Overview:
Fetch sequencer between the PC/redirect sources and the I-cache. It arbitrates redirect requests from exceptions, the BRU and the BPU, and issues at most MAX_OUT pipelined 8-byte fetch requests. It drops stale responses after a redirect and buffers returned instruction pairs for the Instruction Queue. It sits in front of the I-cache port and replaces free-running PC+8 stepping with credit-based issue.

Parameters:
ADDR_WIDTH, 32, fetch address width
BOOT_ADDR, 32'h0000_0000, PC loaded on reset
MAX_OUT, 2, max outstanding I-cache requests (1..3)
BUF_DEPTH, 2, response buffer entries (power of 2, >= MAX_OUT)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
exc_redirect_i  in  1  exception/trap redirect, highest priority
exc_addr_i  in  ADDR_WIDTH  trap target
bru_miss_i  in  1  branch mispredict redirect
bru_addr_i  in  ADDR_WIDTH  corrected target
bpu_taken_i  in  1  predicted taken for the request handshaking this cycle
bpu_addr_i  in  ADDR_WIDTH  predicted target
interrupt_stall_i  in  1  hold new issue
icache_req_valid_o  out  1  fetch request valid
icache_req_addr_o  out  ADDR_WIDTH  fetch address (8-byte pair)
icache_req_ready_i  in  1  I-cache accepts request
icache_resp_valid_i  in  1  response valid, in request order
icache_resp_data_i  in  64  {inst1, inst0}
inst_valid_o  out  1  buffer head valid
inst0_o  out  32  head bits [31:0]
inst1_o  out  32  head bits [63:32]
inst_pc_o  out  ADDR_WIDTH  head fetch address
instr_queue_ready_i  in  1  consumer pops head
misaligned_exception_o  out  1  fault on redirect to non-4-byte-aligned target
misaligned_addr_o  out  ADDR_WIDTH  faulting target

Behaviour:
- Reset, asynchronous and active-high:
  - pc=BOOT_ADDR, state=RUN, outstanding=0, drop_cnt=0, buffer empty.
  - All outputs are 0 except icache_req_addr_o=BOOT_ADDR.
- Redirect priority: exc_redirect_i > bru_miss_i > bpu_taken_i. Define redir = exc|bru.
- States:
  - RUN: issue allowed.
  - HOLD: interrupt_stall_i is high; no issue.
  - FAULT: misaligned target; no issue.
- Transitions:
  - RUN->HOLD when interrupt_stall_i=1. HOLD->RUN when it is 0.
  - Any state -> FAULT when redir is taken with target[1:0]!=0.
  - FAULT is left only by exc_redirect_i with an aligned target, which goes to RUN.
  - bru_miss_i in FAULT is ignored.
- icache_req_valid_o = (state==RUN) & !redir & (outstanding + buf_count < BUF_DEPTH) & (outstanding < MAX_OUT). This guarantees buffer space for every in-flight response.
- On request handshake: pc <= bpu_taken_i ? {bpu_addr_i[ADDR_WIDTH-1:2],2'b00} : pc+8, modulo 2^ADDR_WIDTH. outstanding increments.
- On accepted redir (aligned): next cycle pc=target.
  - drop_cnt <= outstanding minus any response arriving that same cycle.
  - Buffer is flushed; an in-flight pop that cycle is discarded.
- Response handling:
  - If drop_cnt>0, the response is discarded and drop_cnt decrements.
  - Otherwise it is pushed with the PC recorded in a MAX_OUT-deep issue-address FIFO.
  - Every response decrements outstanding. Simultaneous issue and response leaves outstanding unchanged.
- Push and pop in the same cycle are allowed when the buffer is full. Pop happens when inst_valid_o & instr_queue_ready_i.
- Buffer head outputs are registered; no combinational path from icache_resp_* to inst_*_o.
- misaligned_exception_o and misaligned_addr_o:
  - Set the cycle after FAULT entry.
  - Held until FAULT exits; cleared on exit.
  - Buffer is flushed on entry.
- Response with outstanding==0 is a protocol error; it is ignored, and an assertion fires in simulation.

Optional Feature:
FETCH_SCHED_PERF_EN:
- When defined, adds outputs perf_redirect_cnt_o[31:0] and perf_starve_cnt_o[31:0].
  - perf_redirect_cnt_o counts accepted redirects.
  - perf_starve_cnt_o counts cycles with instr_queue_ready_i=1 and inst_valid_o=0.
- Both reset to 0, saturate at all-ones, and do not count in FAULT.
- When undefined, the ports and logic are absent and behaviour is otherwise identical.

Test Plan:
- Reset, ready always 1, 1-cycle response latency -> requests at 0x0, 0x8, 0x10; inst_pc_o follows the same order; never more than 2 outstanding.
- bpu_taken_i=1, bpu_addr_i=0x100 on handshake at 0x8 -> next request 0x100.
- Two requests outstanding, then bru_miss_i to 0x200 -> both responses dropped, buffer flushed, next request 0x200, no inst_valid_o with pc 0x8/0x10.
- Same cycle exc_redirect_i=0x80 and bru_miss_i=0x200 -> next request 0x80.
- bru_miss_i to 0x202 -> misaligned_exception_o=1 and misaligned_addr_o=0x202 next cycle, no issue; exc_redirect_i to 0x40 -> clears, fetch resumes at 0x40.
- instr_queue_ready_i=0 for 10 cycles -> buffer fills to 2, issue stops; interrupt_stall_i mid-run -> no new issue, outstanding responses still buffered.
